// File: rtl/inst_fifo.sv
// Dual-port instruction buffer between fetch and dual-issue decode.
// Up to two {pc, inst} pushes and two pops per cycle, with show-ahead read ports.
module inst_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        fifo_rst,
  input  logic        write_en1,
  input  logic        write_en2,
  input  logic [31:0] write_inst1,
  input  logic [31:0] write_inst2,
  input  logic [31:0] write_pc1,
  input  logic [31:0] write_pc2,
  input  logic        read_en1,
  input  logic        read_en2,
  output logic [31:0] read_inst1,
  output logic [31:0] read_pc1,
  output logic [31:0] read_inst2,
  output logic [31:0] read_pc2,
  output logic        empty,
  output logic        almost_empty,
  output logic        full
);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   count;

  logic [AW-1:0] wp_p1;
  logic [AW-1:0] rp_p1;
  logic [AW:0]   nw;
  logic [AW:0]   nr;
  logic [AW:0]   nr_req;
  logic [63:0]   head1;
  logic [63:0]   head2;

  assign wp_p1 = wp + AW'(1);
  assign rp_p1 = rp + AW'(1);

  assign empty        = (count == '0);
  assign almost_empty = (count == (AW+1)'(1));
  assign full         = (count > (AW+1)'(DEPTH - 2));

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    nw = '0;
    if (!full && write_en1)
      nw = write_en2 ? (AW+1)'(2) : (AW+1)'(1);

    nr_req = '0;
    if (read_en1)
      nr_req = read_en2 ? (AW+1)'(2) : (AW+1)'(1);
    nr = (nr_req > count) ? count : nr_req;
  end

  // NOTE: storage has no reset; validity is tracked by count, and the read mask hides stale words.
  always_ff @(posedge clk) begin
    if (!fifo_rst && nw != '0) begin
      mem[wp] <= {write_pc1, write_inst1};
      if (nw == (AW+1)'(2))
        mem[wp_p1] <= {write_pc2, write_inst2};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (fifo_rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      wp    <= wp + nw[AW-1:0];
      rp    <= rp + nr[AW-1:0];
      count <= count + nw - nr;
    end
  end

  // Slots beyond the current occupancy read as zero so decode never sees stale data.
  always_comb begin
    head1 = '0;
    head2 = '0;
    if (count != '0)
      head1 = mem[rp];
    if (count > (AW+1)'(1))
      head2 = mem[rp_p1];
  end

  assign {read_pc1, read_inst1} = head1;
  assign {read_pc2, read_inst2} = head2;

endmodule

// File: tb/tb_inst_fifo.sv
// Scoreboard bench for inst_fifo: a queue holds expected {pc, inst} entries in
// fetch order; pops are compared against its head, status against its size.
module tb_inst_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        resetn;
  logic        fifo_rst;
  logic        write_en1, write_en2;
  logic [31:0] write_inst1, write_inst2, write_pc1, write_pc2;
  logic        read_en1, read_en2;
  logic [31:0] read_inst1, read_pc1, read_inst2, read_pc2;
  logic        empty, almost_empty, full;

  inst_fifo #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .fifo_rst     (fifo_rst),
    .write_en1    (write_en1),
    .write_en2    (write_en2),
    .write_inst1  (write_inst1),
    .write_inst2  (write_inst2),
    .write_pc1    (write_pc1),
    .write_pc2    (write_pc2),
    .read_en1     (read_en1),
    .read_en2     (read_en2),
    .read_inst1   (read_inst1),
    .read_pc1     (read_pc1),
    .read_inst2   (read_inst2),
    .read_pc2     (read_pc2),
    .empty        (empty),
    .almost_empty (almost_empty),
    .full         (full)
  );

  always #5 clk = ~clk;

  logic [63:0] sb [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0F0F;
  endfunction

  // Compare all outputs against the scoreboard's current contents.
  task automatic check_state(input string tag);
    logic [63:0] e1, e2;
    e1 = (sb.size() > 0) ? sb[0] : 64'd0;
    e2 = (sb.size() > 1) ? sb[1] : 64'd0;
    check({tag, ".empty"},  64'(empty),        64'(sb.size() == 0));
    check({tag, ".aempty"}, 64'(almost_empty), 64'(sb.size() == 1));
    check({tag, ".full"},   64'(full),         64'(sb.size() > DEPTH - 2));
    check({tag, ".slot1"},  {read_pc1, read_inst1}, e1);
    check({tag, ".slot2"},  {read_pc2, read_inst2}, e2);
  endtask

  // One clock of stimulus: drive at negedge, score pops/pushes, check after the edge.
  task automatic step(input string tag,
                      input logic we1, input logic we2,
                      input logic [31:0] p1, input logic [31:0] i1,
                      input logic [31:0] p2, input logic [31:0] i2,
                      input logic re1, input logic re2, input logic fl,
                      output int pushed, output int popped);
    int sz, req;
    logic [63:0] exp;
    @(negedge clk);
    write_en1 = we1; write_en2 = we2;
    write_pc1 = p1;  write_inst1 = i1;
    write_pc2 = p2;  write_inst2 = i2;
    read_en1 = re1;  read_en2 = re2;
    fifo_rst = fl;
    #1;
    pushed = 0;
    popped = 0;
    sz = sb.size();
    if (fl) begin
      sb.delete();
    end else begin
      req = re1 ? (re2 ? 2 : 1) : 0;
      popped = (req > sz) ? sz : req;
      for (int k = 0; k < popped; k++) begin
        exp = sb.pop_front();
        if (k == 0) check({tag, ".pop1"}, {read_pc1, read_inst1}, exp);
        else        check({tag, ".pop2"}, {read_pc2, read_inst2}, exp);
      end
      if (!(sz > DEPTH - 2) && we1) begin
        sb.push_back({p1, i1});
        pushed = 1;
        if (we2) begin
          sb.push_back({p2, i2});
          pushed = 2;
        end
      end
    end
    @(posedge clk);
    #1;
    check_state(tag);
  endtask

  task automatic push(input string tag, input int n, input logic [31:0] pc);
    int pu, po;
    step(tag, n > 0, n > 1, pc, inst_of(pc), pc + 4, inst_of(pc + 4), 1'b0, 1'b0, 1'b0, pu, po);
  endtask

  task automatic pop(input string tag, input int n);
    int pu, po;
    step(tag, 1'b0, 1'b0, '0, '0, '0, '0, n > 0, n > 1, 1'b0, pu, po);
  endtask

  initial begin
    int pu, po;
    int next_i, popped_i;
    resetn = 1'b0; fifo_rst = 1'b0;
    write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0;
    write_pc1 = '0; write_pc2 = '0; write_inst1 = '0; write_inst2 = '0;
    #3;
    check_state("reset");
    #9 resetn = 1'b1;

    // Dual push, dual pop.
    step("dual_push", 1'b1, 1'b1, 32'hBFC0_0000, 32'h2401_0001, 32'hBFC0_0004, 32'h2402_0002,
         1'b0, 1'b0, 1'b0, pu, po);
    check("dual_push.pc1", 64'(read_pc1), 64'h0000_0000_BFC0_0000);
    check("dual_push.pc2", 64'(read_pc2), 64'h0000_0000_BFC0_0004);
    pop("dual_pop", 2);
    check("dual_pop.empty", 64'(empty), 64'd1);

    // Three in, two out: one left, slave slot masked; dual pop then takes only one.
    push("three_a", 2, 32'h1000);
    push("three_b", 1, 32'h1008);
    pop("three_pop", 2);
    check("single.aempty", 64'(almost_empty), 64'd1);
    check("single.inst2", 64'(read_inst2), 64'd0);
    pop("single_pop", 2);
    check("single.empty", 64'(empty), 64'd1);

    // Pop 2 plus push 2 at count 2: occupancy stays 2 and shows the new pair.
    push("net_a", 2, 32'h2000);
    step("net_b", 1'b1, 1'b1, 32'h3000, 32'h1111_1111, 32'h3004, 32'h2222_2222,
         1'b1, 1'b1, 1'b0, pu, po);
    check("net.pc1", 64'(read_pc1), 64'h3000);
    pop("net_drain", 2);

    // Full backpressure: 1 + 7*2 = 15 entries.
    push("fill_1", 1, 32'h4000);
    for (int k = 0; k < 7; k++) push("fill_2", 2, 32'h4004 + 32'(8 * k));
    check("full.at15", 64'(full), 64'd1);
    step("full_drop", 1'b1, 1'b1, 32'hDEAD_0000, 32'h0, 32'hDEAD_0004, 32'h0,
         1'b0, 1'b0, 1'b0, pu, po);
    check("full.dropped", 64'(pu), 64'd0);
    pop("full_pop", 2);
    check("full.cleared", 64'(full), 64'd0);
    for (int k = 0; k < 7; k++) pop("full_drain", 2);
    check("full.drained", 64'(empty), 64'd1);

    // Wrap-around: 40 entries with pc = 4*i through mixed 1/2 pushes and pops.
    next_i = 0;
    popped_i = 0;
    for (int c = 0; c < 600 && popped_i < 40; c++) begin
      logic we1, we2, re1, re2;
      we1 = (next_i < 40) && ($urandom_range(0, 3) != 0);
      we2 = we1 && (next_i + 1 < 40) && ($urandom_range(0, 1) != 0);
      re1 = ($urandom_range(0, 2) != 0);
      re2 = ($urandom_range(0, 1) != 0);
      step("wrap", we1, we2, 32'(4 * next_i), inst_of(32'(4 * next_i)),
           32'(4 * (next_i + 1)), inst_of(32'(4 * (next_i + 1))), re1, re2, 1'b0, pu, po);
      next_i += pu;
      popped_i += po;
    end
    check("wrap.pushed", 64'(next_i), 64'd40);
    check("wrap.popped", 64'(popped_i), 64'd40);

    // Flush beats a simultaneous dual push and dual pop.
    for (int k = 0; k < 3; k++) push("flush_fill", 2, 32'h5000 + 32'(8 * k));
    step("flush", 1'b1, 1'b1, 32'h6000, 32'h0, 32'h6004, 32'h0, 1'b1, 1'b1, 1'b1, pu, po);
    check("flush.empty", 64'(empty), 64'd1);
    check("flush.inst1", 64'(read_inst1), 64'd0);
    push("flush_after", 1, 32'h8000_0180);
    check("flush.newpc", 64'(read_pc1), 64'h8000_0180);
    step("flush_empty_pop", 1'b0, 1'b0, '0, '0, '0, '0, 1'b1, 1'b1, 1'b1, pu, po);
    pop("underflow", 2);

    // Asynchronous reset with 5 entries held.
    push("rst_a", 2, 32'h7000);
    push("rst_b", 2, 32'h7008);
    push("rst_c", 1, 32'h7010);
    @(negedge clk);
    write_en1 = 1'b0; write_en2 = 1'b0; read_en1 = 1'b0; read_en2 = 1'b0; fifo_rst = 1'b1;
    #2 resetn = 1'b0;
    #1;
    sb.delete();
    check("async.empty", 64'(empty), 64'd1);
    check("async.full", 64'(full), 64'd0);
    check("async.inst1", 64'(read_inst1), 64'd0);
    @(negedge clk);
    fifo_rst = 1'b0;
    #2 resetn = 1'b1;
    pop("post_reset_pop", 1);
    push("post_reset_push", 1, 32'h9000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end
endmodule
